// File: rtl/dma_bus_arbiter_if.sv
// Bus-side signal bundle for the DMA bus arbiter.
// The master modport is the grant-issuing side (the arbiter).
// The slave modport is the requester/bus side that drives requests
// and transaction strobes.
interface dma_bus_arbiter_if #(
   parameter int NrOfMasters = 4
);
   logic [NrOfMasters-1:0] request;
   logic [NrOfMasters-1:0] granted;
   logic                   begin_transactionIN;
   logic                   end_transactionIN;
   logic                   errorIN;
   logic                   errorOUT;
   logic                   bus_idle;

   modport master (
      input  request,
      input  begin_transactionIN,
      input  end_transactionIN,
      input  errorIN,
      output granted,
      output errorOUT,
      output bus_idle
   );

   modport slave (
      output request,
      output begin_transactionIN,
      output end_transactionIN,
      output errorIN,
      input  granted,
      input  errorOUT,
      input  bus_idle
   );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Round-robin DMA bus arbiter.
// It grants one master at a time. A begin-timeout limits how long a grant
// may sit unused. A watchdog limits how long one transaction may run.
// All outputs are registered. After every grant there is a RELEASE cycle
// and then an IDLE cycle.
module dma_bus_arbiter #(
   parameter int NrOfMasters    = 4,
   parameter int BeginTimeout   = 16,
   parameter int WatchdogCycles = 256
) (
   input logic               clock,
   input logic               reset,
   dma_bus_arbiter_if.master bus
);
   localparam int LgW = $clog2(NrOfMasters);
   localparam int BcW = (BeginTimeout > 1) ? $clog2(BeginTimeout) : 1;
   localparam int WdW = (WatchdogCycles > 1) ? $clog2(WatchdogCycles) : 1;
   localparam logic [BcW-1:0] BcLast   = BcW'(BeginTimeout - 1);
   localparam logic [WdW-1:0] WdLast   = WdW'(WatchdogCycles - 1);
   localparam logic [LgW-1:0] LastInit = LgW'(NrOfMasters - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BUSY,
      RELEASE
   } state_t;

   state_t                 state;
   logic [LgW-1:0]         last_grant;
   logic [LgW-1:0]         sel_idx;
   logic [LgW-1:0]         cand;
   logic                   sel_found;
   logic [NrOfMasters-1:0] sel_onehot;
   logic [BcW-1:0]         begin_cnt;
   logic [WdW-1:0]         wd_cnt;

   // Round-robin pick: scan from last_grant+1 with wraparound; the first requester found wins
   always_comb begin
      sel_idx    = last_grant;
      sel_found  = 1'b0;
      cand       = '0;
      sel_onehot = '0;
      for (int unsigned i = 1; i <= NrOfMasters; i++) begin
         cand = LgW'((32'(last_grant) + i) % NrOfMasters);
         if (!sel_found && bus.request[cand]) begin
            sel_idx   = cand;
            sel_found = 1'b1;
         end
      end
      sel_onehot[sel_idx] = 1'b1;
   end

   // Arbiter FSM with registered grant/error/idle outputs; last_grant doubles as the grantee index
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         bus.granted  <= '0;
         bus.errorOUT <= 1'b0;
         bus.bus_idle <= 1'b1;
         last_grant   <= LastInit;
         begin_cnt    <= '0;
         wd_cnt       <= '0;
      end else begin
         bus.errorOUT <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_found) begin
                  state        <= GRANT;
                  bus.granted  <= sel_onehot;
                  bus.bus_idle <= 1'b0;
                  last_grant   <= sel_idx;
                  begin_cnt    <= '0;
               end else begin
                  bus.granted <= '0;
               end
            end
            GRANT: begin
               if (bus.errorIN) begin
                  state       <= RELEASE;
                  bus.granted <= '0;
               end else if (bus.begin_transactionIN) begin
                  state  <= BUSY;
                  wd_cnt <= '0;
               end else if (!bus.request[last_grant] || begin_cnt == BcLast) begin
                  state       <= RELEASE;
                  bus.granted <= '0;
               end else begin
                  begin_cnt <= begin_cnt + 1'b1;
               end
            end
            BUSY: begin
               // end_transactionIN is checked before the watchdog, so a coincident end suppresses the error pulse
               if (bus.errorIN || bus.end_transactionIN) begin
                  state       <= RELEASE;
                  bus.granted <= '0;
               end else if (wd_cnt == WdLast) begin
                  state        <= RELEASE;
                  bus.granted  <= '0;
                  bus.errorOUT <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            RELEASE: begin
               state        <= IDLE;
               bus.granted  <= '0;
               bus.bus_idle <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               bus.granted  <= '0;
               bus.bus_idle <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter.
// The driver plans each grant episode and pushes the expected grantee,
// grant length and error outcome. These come from an episode-level
// round-robin model. A monitor measures each observed grant and compares
// it with the queued expectation.
module tb_dma_bus_arbiter;
   localparam int NM = 4;
   localparam int BT = 16;
   localparam int WD = 256;

   typedef struct {
      int master;
      int len;
      bit err;
   } exp_t;

   logic clock;
   logic reset;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   model_last = NM - 1;

   dma_bus_arbiter_if #(.NrOfMasters(NM)) bif ();

   dma_bus_arbiter #(
      .NrOfMasters(NM),
      .BeginTimeout(BT),
      .WatchdogCycles(WD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bif)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [NM-1:0] onehot(input int idx);
      logic [NM-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input logic [NM-1:0] req);
      for (int i = 1; i <= NM; i++) begin
         int idx;
         idx = (model_last + i) % NM;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   // scen: 0 normal, 1 begin timeout, 2 request drop, 3 errorIN in GRANT,
   //       4 errorIN in BUSY, 5 watchdog expiry, 6 end on watchdog cycle
   function automatic void model_episode(input logic [NM-1:0] req, input int scen, input int b,
                                         input int x, output int win, output int len, output bit err);
      win        = rr_pick(req);
      model_last = win;
      err        = 1'b0;
      case (scen)
         0, 4:    len = b + 2 + x;
         1:       len = BT;
         2, 3:    len = x + 1;
         5: begin len = b + 1 + WD; err = 1'b1; end
         default: len = b + 1 + WD;
      endcase
   endfunction

   task automatic idle_noise();
      bif.begin_transactionIN = 1'($urandom_range(0, 1));
      bif.end_transactionIN   = 1'($urandom_range(0, 1));
      bif.errorIN             = 1'($urandom_range(0, 1));
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge of the RELEASE cycle
   task automatic run_episode(input logic [NM-1:0] req, input int scen, input int b, input int x);
      int            win;
      int            len;
      bit            err;
      bit            uses_begin;
      logic [NM-1:0] cur;
      model_episode(req, scen, b, x, win, len, err);
      sb.push_back('{win, len, err});
      uses_begin = (scen == 0) || (scen >= 4);
      cur = req;
      bif.request = cur;
      idle_noise();
      for (int k = 1; k <= len + 1; k++) begin
         int cyc;
         @(negedge clock);
         cyc = k - 1;
         if (k == len + 1) begin
            bif.request = '0;
            idle_noise();
         end else begin
            if (scen == 2 && cyc == x) cur[win] = 1'b0;
            bif.request             = cur;
            bif.begin_transactionIN = uses_begin && (cyc == b);
            bif.end_transactionIN   = (scen == 0 && cyc == b + 1 + x) || (scen == 6 && cyc == b + WD);
            bif.errorIN             = (scen == 3 && cyc == x) || (scen == 4 && cyc == b + 1 + x);
         end
      end
   endtask

   task automatic next_slot(input int gap);
      @(negedge clock);
      for (int g = 0; g < gap; g++) begin
         bif.request = '0;
         idle_noise();
         @(negedge clock);
      end
   endtask

   // Monitor: measures each grant episode and checks it against the scoreboard
   initial begin
      bit            active;
      logic [NM-1:0] gval;
      int            glen;
      exp_t          e;
      active = 1'b0;
      gval   = '0;
      glen   = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            active = 1'b0;
         end else if (bif.granted !== '0) begin
            if (!active) begin
               active = 1'b1;
               gval   = bif.granted;
               glen   = 1;
            end else begin
               check("grant_stable", 64'(bif.granted), 64'(gval));
               glen++;
            end
            check("idle_during_grant", 64'(bif.bus_idle), 64'(0));
            check("no_err_during_grant", 64'(bif.errorOUT), 64'(0));
         end else if (active) begin
            active = 1'b0;
            if (sb.size() == 0) begin
               check("unexpected_grant", 64'(gval), 64'(0));
            end else begin
               e = sb.pop_front();
               check("grant_master", 64'(gval), 64'(onehot(e.master)));
               check("grant_len", 64'(glen), 64'(e.len));
               check("errorOUT_at_release", 64'(bif.errorOUT), 64'(e.err));
            end
            check("idle_in_release", 64'(bif.bus_idle), 64'(0));
         end else begin
            check("idle_when_free", 64'(bif.bus_idle), 64'(1));
            check("no_err_when_free", 64'(bif.errorOUT), 64'(0));
         end
      end
   end

   // Stimulus: directed episodes, mid-transaction reset, then random episodes
   initial begin
      reset = 1'b1;
      bif.request = '0;
      bif.begin_transactionIN = 1'b0;
      bif.end_transactionIN = 1'b0;
      bif.errorIN = 1'b0;
      #1;
      check("reset_granted", 64'(bif.granted), 64'(0));
      check("reset_errorOUT", 64'(bif.errorOUT), 64'(0));
      check("reset_bus_idle", 64'(bif.bus_idle), 64'(1));
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 5; i++) begin
         run_episode(4'b1111, 0, $urandom_range(0, 11), $urandom_range(0, 20));
         next_slot(0);
      end
      run_episode(4'b0100, 1, 0, 0);
      next_slot(0);
      run_episode(4'b0010, 5, 0, 0);
      next_slot(0);
      run_episode(4'b0100, 4, 2, 5);
      next_slot(1);
      run_episode(4'b0001, 6, 1, 0);
      next_slot(0);

      bif.request = 4'b1000;
      bif.begin_transactionIN = 1'b0;
      bif.end_transactionIN = 1'b0;
      bif.errorIN = 1'b0;
      @(negedge clock);
      bif.begin_transactionIN = 1'b1;
      @(negedge clock);
      bif.begin_transactionIN = 1'b0;
      @(negedge clock);
      check("pre_reset_grant", 64'(bif.granted), 64'(4'b1000));
      #2 reset = 1'b1;
      #1;
      check("async_reset_granted", 64'(bif.granted), 64'(0));
      check("async_reset_errorOUT", 64'(bif.errorOUT), 64'(0));
      check("async_reset_bus_idle", 64'(bif.bus_idle), 64'(1));
      model_last = NM - 1;
      bif.request = '0;
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      run_episode(4'b1111, 0, 1, 1);
      next_slot(0);

      for (int i = 0; i < 40; i++) begin
         int r;
         int scen;
         int b;
         int x;
         r = $urandom_range(0, 19);
         if (r == 0) scen = 5;
         else if (r == 1) scen = 6;
         else scen = $urandom_range(0, 4);
         b = $urandom_range(0, 11);
         x = (scen == 2 || scen == 3) ? $urandom_range(0, 11) : $urandom_range(0, 20);
         run_episode(NM'($urandom_range(1, (1 << NM) - 1)), scen, b, x);
         next_slot($urandom_range(0, 2));
      end

      repeat (3) @(negedge clock);
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NrOfMasters, default 4, meaning the number of bus requesters (2..8).
REQ-002 The block SHALL have parameter BeginTimeout, default 16, meaning the cycles a granted master has to assert begin_transaction.
REQ-003 The block SHALL have parameter WatchdogCycles, default 256, meaning the maximum cycles from begin to end of one transaction.
REQ-004 The block SHALL have clock, input, 1, system clock; all state changes on rising edge.
REQ-005 The block SHALL have reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have request, input, NrOfMasters, one request line per master.
REQ-007 The block SHALL have granted, output, NrOfMasters, registered one-hot (or zero) grant vector.
REQ-008 The block SHALL have begin_transactionIN, input, 1, OR of all masters' begin_transaction.
REQ-009 The block SHALL have end_transactionIN, input, 1, bus end_transaction.
REQ-010 The block SHALL have errorIN, input, 1, bus error from a slave.
REQ-011 The block SHALL have errorOUT, output, 1, one-cycle bus error pulse on watchdog expiry.
REQ-012 The block SHALL have bus_idle, output, 1, high only in state IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT, BUSY, RELEASE.
REQ-014 IDLE: if any request bit set -> GRANT next cycle, granted set to the selected master's bit; else stay IDLE, granted=0.
REQ-015 Selection SHALL be round-robin: search starts at lastGrant+1, wraps modulo NrOfMasters; first set request bit wins.
REQ-016 lastGrant SHALL update to the selected index on every IDLE->GRANT transition.
REQ-017 GRANT: begin_transactionIN=1 -> BUSY; granted master deasserts request -> RELEASE; BeginTimeout cycles elapsed in GRANT without begin -> RELEASE, no error.
REQ-018 BUSY: end_transactionIN=1 -> RELEASE; grant SHALL remain asserted through the cycle in which end_transactionIN is sampled high.
REQ-019 BUSY: watchdog counter counts cycles in BUSY; on reaching WatchdogCycles-1 without end_transactionIN -> errorOUT=1 for exactly one cycle, next state RELEASE.
REQ-020 end_transactionIN and watchdog expiry in the same cycle: end wins, no errorOUT.
REQ-021 errorIN=1 in GRANT or BUSY SHALL force RELEASE next cycle, no errorOUT; errorIN in IDLE or RELEASE SHALL be ignored.
REQ-022 RELEASE: granted=0, lasts exactly one cycle, then IDLE.
REQ-023 granted SHALL be zero in IDLE and RELEASE and equal the selected one-hot bit in GRANT and BUSY.
REQ-024 Minimum gap between two grants SHALL be two cycles (RELEASE, IDLE).
REQ-025 begin_transactionIN or end_transactionIN in IDLE SHALL be ignored.
REQ-026 Both counters SHALL clear on entry to GRANT and BUSY respectively and be width ceil(log2) of their parameter, no wrap.

Reset
REQ-027 reset=1 SHALL asynchronously force state IDLE, granted=0, errorOUT=0, bus_idle=1, counters=0.
REQ-028 reset SHALL set lastGrant=NrOfMasters-1 so master 0 has first priority.
REQ-029 reset mid-transaction SHALL drop the grant immediately without errorOUT.

Verification
REQ-030 After reset, request=4'b1111 held, each master completes begin/end -> grants in order 0,1,2,3,0.
REQ-031 request=4'b0100, begin never asserted -> granted=4'b0100 for 16 cycles, then 0, errorOUT stays 0.
REQ-032 Grant master 1, begin, no end -> errorOUT one-cycle pulse 256 cycles after BUSY entry, granted=0 next cycle.
REQ-033 Grant master 2, begin, errorIN pulse mid-transaction -> granted=0 next cycle, RELEASE then IDLE, errorOUT=0.
REQ-034 Grant master 3 in BUSY, assert reset -> granted=0 same cycle, next grant after reset goes to master 0.
REQ-035 end_transactionIN coincident with watchdog expiry cycle -> no errorOUT, normal RELEASE.
